fp_addsub_mul_backend: RTL and testbench
========================================

FP_ADDSUB_MUL_BACKEND -- requirements
Module: fp_addsub_mul_backend

Interface
REQ-001 Parameter FP_WIDTH, default 32, IEEE-754 word width.
REQ-002 Parameter EXP_WIDTH, default 8, exponent width.
REQ-003 Parameter FRAC_WIDTH, default 23, stored fraction width.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 add_i  in  1  adder operation: 1 = opa+opb, 0 = opa-opb.
REQ-007 add_opa_i, add_opb_i  in  28 each  aligned fraction operands.
REQ-008 add_sum_o  out  27  low 27 bits of the adder result.
REQ-009 add_co_o  out  1  bit 27 of the adder result.
REQ-010 mul_fracta_i, mul_fractb_i  in  24 each  fractions including hidden bit.
REQ-011 mul_fract_o  out  48  registered product.
REQ-012 opa_i, opb_i  in  32 each  original single-precision operands.
REQ-013 fract_28_i  in  28  adder result: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-014 exp_i  in  8  common exponent (larger operand's; denormal inputs use 1).
REQ-015 sign_i  in  1  result sign from pre-normalisation.
REQ-016 fpu_op_i  in  1  0 = add, 1 = subtract.
REQ-017 rmode_i  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
REQ-018 output_o  out  32  normalised, rounded result (registered).
REQ-019 ine_o  out  1  inexact flag (registered).

Function
REQ-020 Adder SHALL be combinational: {add_co_o, add_sum_o} = (add_opa_i ± add_opb_i) mod 2^28.
REQ-021 Multiplier SHALL register mul_fracta_i*mul_fractb_i (unsigned, full 48 bits) into mul_fract_o; latency 1 cycle.
REQ-022 Post-norm SHALL compute combinationally from its inputs and register output_o/ine_o; latency 1 cycle.
REQ-023 If fract_28_i[27]=1: shift right 1, exponent exp_i+1, and OR the shifted-out bit into sticky.
REQ-024 Else: count leading zeros lz of fract_28_i[26:0]. If exp_i>lz, shift left lz and set exponent exp_i-lz. Otherwise shift left exp_i-1 and set exponent 0 (denormal).
REQ-025 After normalisation, mantissa = bits [26:3], lsb = bit [3], and g/r/s = [2]/[1]/[0].
REQ-026 Round-up conditions: nearest-even when g&(r|s|lsb). Toward zero: never. +inf when !sign_i&(g|r|s). -inf when sign_i&(g|r|s).
REQ-027 Rounding carry out of 24 bits: shift right 1, exponent +1.
REQ-028 Denormal whose hidden bit becomes 1 after rounding: exponent becomes 1.
REQ-029 ine_o SHALL be 1 when g|r|s is nonzero after normalisation, or on overflow.
REQ-030 Exponent reaching 255 after rounding: output {sign_i, 8'hFF, 23'h0}, ine_o=1.
REQ-031 Either operand NaN (exp FF, fraction≠0): output 0x7FC00000, ine_o=0.
REQ-032 Infinity minus infinity (effective subtraction of infinities): output 0x7FC00000.
REQ-033 Any other infinite operand: output ±inf, using the operand's sign; opb's sign is inverted when fpu_op_i=1.
REQ-034 Exact zero result from cancellation: +0, except -0 when rmode_i=11.
REQ-035 Both operands zero with equal effective sign: that sign.

Reset
REQ-036 rst_ni low SHALL asynchronously clear mul_fract_o, output_o and ine_o to 0.
REQ-037 Registers SHALL first load on the first rising edge after rst_ni deasserts.
REQ-038 The adder path is unaffected by reset.

Structure
REQ-039 A shared package SHALL hold FP_WIDTH/EXP_WIDTH/FRAC_WIDTH, the constants QNAN=0x7FC00000 and INF magnitude 0x7F800000, and the rounding-mode encodings.
REQ-040 One sub-module SHALL exist: fp_lzc28, a 27-bit leading-zero counter; the adder and multiplier are inline.

Verification
REQ-041 Adder: add=1, opa=opb=28'h4000000 -> co=1, sum=0. Adder: add=0, opa=28'h4000000, opb=28'h2000000 -> co=0, sum=27'h2000000.
REQ-042 Multiplier: 24'h800000 × 24'h800000 -> mul_fract_o=48'h400000000000 one cycle later.
REQ-043 1.0+1.0: opa=opb=0x3F800000, fract_28_i=28'h8000000, exp_i=0x7F, rmode 00 -> output_o=0x40000000, ine_o=0.
REQ-044 Tie-to-even: fract_28_i=28'h4000004 (g=1, lsb=0), exp_i=0x7F, rmode 00 -> 0x3F800000 with ine_o=1; same input with rmode 10, sign 0 -> 0x3F800001.
REQ-045 Inf-inf: opa=opb=0x7F800000, fpu_op_i=1 -> 0x7FC00000. Exact cancellation with fract_28_i=0, rmode 11 -> 0x80000000.
REQ-046 Reset: assert rst_ni mid-operation -> output_o, ine_o, mul_fract_o read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fp_addsub_mul_backend_pkg.sv
// Shared constants and types for the FP add/sub/mul back end.
// Holds the IEEE-754 single-precision field widths, the canonical quiet NaN,
// the infinity magnitude and the rounding-mode encodings.
package fp_addsub_mul_backend_pkg;

    localparam int FP_WIDTH   = 32;
    localparam int EXP_WIDTH  = 8;
    localparam int FRAC_WIDTH = 23;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;

    typedef enum logic [1:0] {
        RM_NEAREST_EVEN = 2'b00,
        RM_TOWARD_ZERO  = 2'b01,
        RM_TOWARD_PINF  = 2'b10,
        RM_TOWARD_NINF  = 2'b11
    } rmode_e;

endpackage

// File: rtl/fp_addsub_mul_backend_lzc.sv
// fp_lzc28: leading-zero counter for the 27 low bits of the adder result
// (hidden bit down to sticky).
// Ports: d_i   - 27-bit value, bit 26 is the most significant
//        cnt_o - number of leading zeros, 0..27 (27 when d_i is zero)
module fp_lzc28 (
    input  logic [26:0] d_i,
    output logic [4:0]  cnt_o
);

    // Ascending scan: the last hit is the highest set bit, which sets the count.
    always_comb begin
        cnt_o = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (d_i[i]) cnt_o = 5'(26 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_mul_backend.sv
// Back end of a single-precision FP unit.
// - Adder: combinational 28-bit add/subtract of aligned fractions.
// - Multiplier: registered 24x24 unsigned fraction product (1 cycle).
// - Post-normalisation: normalise, round and handle special operands,
//   result registered (1 cycle).
// Ports: clk_i/rst_ni clock and async active-low reset; add_* adder I/O;
//        mul_* multiplier I/O; opa_i/opb_i/fract_28_i/exp_i/sign_i/fpu_op_i/
//        rmode_i post-norm inputs; output_o/ine_o registered result and
//        inexact flag.
module fp_addsub_mul_backend #(
    parameter int FP_WIDTH   = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 add_i,
    input  logic [27:0]          add_opa_i,
    input  logic [27:0]          add_opb_i,
    output logic [26:0]          add_sum_o,
    output logic                 add_co_o,
    input  logic [23:0]          mul_fracta_i,
    input  logic [23:0]          mul_fractb_i,
    output logic [47:0]          mul_fract_o,
    input  logic [FP_WIDTH-1:0]  opa_i,
    input  logic [FP_WIDTH-1:0]  opb_i,
    input  logic [27:0]          fract_28_i,
    input  logic [EXP_WIDTH-1:0] exp_i,
    input  logic                 sign_i,
    input  logic                 fpu_op_i,
    input  logic [1:0]           rmode_i,
    output logic [FP_WIDTH-1:0]  output_o,
    output logic                 ine_o
);
    import fp_addsub_mul_backend_pkg::*;

    localparam int EW = EXP_WIDTH + 2;  // headroom for +1 overflow checks
    localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_WIDTH{1'b1}}};

    // ---------------- adder (combinational, no reset) ----------------
    always_comb begin
        if (add_i) {add_co_o, add_sum_o} = add_opa_i + add_opb_i;
        else       {add_co_o, add_sum_o} = add_opa_i - add_opb_i;
    end

    // ---------------- multiplier ----------------
    logic [47:0] mul_fract_d, mul_fract_q;
    assign mul_fract_d = mul_fracta_i * mul_fractb_i;
    assign mul_fract_o = mul_fract_q;

    // ---------------- post-normalisation ----------------
    logic [4:0]            lz;
    logic [4:0]            dn_shift;
    logic [26:0]           norm;
    logic [EW-1:0]         exp_ext, exp_n, exp_r;
    logic                  g, r, s, lsb, round_up;
    logic [24:0]           mant_r;
    logic [23:0]           mant;
    logic                  opa_nan, opb_nan, opa_inf, opb_inf, opb_sign_eff;
    logic [FP_WIDTH-1:0]   output_d, output_q;
    logic                  ine_d, ine_q;

    fp_lzc28 u_lzc (
        .d_i   (fract_28_i[26:0]),
        .cnt_o (lz)
    );

    always_comb begin
        exp_ext  = {2'b00, exp_i};
        dn_shift = (exp_i == '0) ? 5'd0 : 5'(exp_i - 1'b1);
        norm     = '0;
        exp_n    = '0;
        if (fract_28_i[27]) begin
            // Carry out: drop one bit, folding it into sticky.
            norm  = {fract_28_i[27:2], fract_28_i[1] | fract_28_i[0]};
            exp_n = exp_ext + 1'b1;
        end else if (exp_ext > {5'b0, lz}) begin
            norm  = fract_28_i[26:0] << lz;
            exp_n = exp_ext - {5'b0, lz};
        end else begin
            // Not enough exponent to fully normalise: result is denormal.
            norm  = fract_28_i[26:0] << dn_shift;
            exp_n = '0;
        end

        lsb = norm[3];
        g   = norm[2];
        r   = norm[1];
        s   = norm[0];

        case (rmode_e'(rmode_i))
            RM_NEAREST_EVEN: round_up = g & (r | s | lsb);
            RM_TOWARD_ZERO:  round_up = 1'b0;
            RM_TOWARD_PINF:  round_up = ~sign_i & (g | r | s);
            default:         round_up = sign_i & (g | r | s);
        endcase

        mant_r = {1'b0, norm[26:3]} + {24'b0, round_up};
        if (mant_r[24]) begin
            mant  = mant_r[24:1];
            exp_r = exp_n + 1'b1;
        end else begin
            mant  = mant_r[23:0];
            // Denormal rounded up into the normal range.
            exp_r = (exp_n == '0 && mant_r[23]) ? EW'(1) : exp_n;
        end

        opa_nan      = &opa_i[FP_WIDTH-2 -: EXP_WIDTH] && (opa_i[FRAC_WIDTH-1:0] != '0);
        opb_nan      = &opb_i[FP_WIDTH-2 -: EXP_WIDTH] && (opb_i[FRAC_WIDTH-1:0] != '0);
        opa_inf      = &opa_i[FP_WIDTH-2 -: EXP_WIDTH] && (opa_i[FRAC_WIDTH-1:0] == '0);
        opb_inf      = &opb_i[FP_WIDTH-2 -: EXP_WIDTH] && (opb_i[FRAC_WIDTH-1:0] == '0);
        opb_sign_eff = opb_i[FP_WIDTH-1] ^ fpu_op_i;

        output_d = {sign_i, exp_r[EXP_WIDTH-1:0], mant[FRAC_WIDTH-1:0]};
        ine_d    = g | r | s;

        if (opa_nan || opb_nan) begin
            output_d = QNAN;
            ine_d    = 1'b0;
        end else if (opa_inf && opb_inf && (opa_i[FP_WIDTH-1] != opb_sign_eff)) begin
            output_d = QNAN;
            ine_d    = 1'b0;
        end else if (opa_inf) begin
            output_d = {opa_i[FP_WIDTH-1], INF_MAG};
            ine_d    = 1'b0;
        end else if (opb_inf) begin
            output_d = {opb_sign_eff, INF_MAG};
            ine_d    = 1'b0;
        end else if (fract_28_i == '0) begin
            ine_d = 1'b0;
            if (opa_i[FP_WIDTH-2:0] == '0 && opb_i[FP_WIDTH-2:0] == '0 &&
                opa_i[FP_WIDTH-1] == opb_sign_eff)
                output_d = {opa_i[FP_WIDTH-1], {(FP_WIDTH-1){1'b0}}};
            else
                output_d = {(rmode_e'(rmode_i) == RM_TOWARD_NINF), {(FP_WIDTH-1){1'b0}}};
        end else if (exp_r >= EXP_MAX) begin
            output_d = {sign_i, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            ine_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mul_fract_q <= '0;
            output_q    <= '0;
            ine_q       <= 1'b0;
        end else begin
            mul_fract_q <= mul_fract_d;
            output_q    <= output_d;
            ine_q       <= ine_d;
        end
    end

    assign output_o = output_q;
    assign ine_o    = ine_q;

endmodule

// File: tb/tb_fp_addsub_mul_backend.sv
// Directed bench for fp_addsub_mul_backend with hand-computed vectors.
module tb_fp_addsub_mul_backend;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        add_i = 1'b0;
    logic [27:0] add_opa_i = '0, add_opb_i = '0;
    logic [26:0] add_sum_o;
    logic        add_co_o;
    logic [23:0] mul_fracta_i = '0, mul_fractb_i = '0;
    logic [47:0] mul_fract_o;
    logic [31:0] opa_i = '0, opb_i = '0;
    logic [27:0] fract_28_i = '0;
    logic [7:0]  exp_i = '0;
    logic        sign_i = 1'b0, fpu_op_i = 1'b0;
    logic [1:0]  rmode_i = 2'b00;
    logic [31:0] output_o;
    logic        ine_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    fp_addsub_mul_backend dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .add_i        (add_i),
        .add_opa_i    (add_opa_i),
        .add_opb_i    (add_opb_i),
        .add_sum_o    (add_sum_o),
        .add_co_o     (add_co_o),
        .mul_fracta_i (mul_fracta_i),
        .mul_fractb_i (mul_fractb_i),
        .mul_fract_o  (mul_fract_o),
        .opa_i        (opa_i),
        .opb_i        (opb_i),
        .fract_28_i   (fract_28_i),
        .exp_i        (exp_i),
        .sign_i       (sign_i),
        .fpu_op_i     (fpu_op_i),
        .rmode_i      (rmode_i),
        .output_o     (output_o),
        .ine_o        (ine_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Apply one post-norm vector after a falling edge, check #1 after the rising edge.
    task automatic pn(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [27:0] f, input logic [7:0] e, input logic sg,
                      input logic op, input logic [1:0] rm,
                      input logic [31:0] exp_out, input logic exp_ine);
        @(negedge clk_i);
        opa_i = a; opb_i = b; fract_28_i = f; exp_i = e;
        sign_i = sg; fpu_op_i = op; rmode_i = rm;
        @(posedge clk_i);
        #1;
        chk({tag, "_out"}, 64'(output_o), 64'(exp_out));
        chk({tag, "_ine"}, 64'(ine_o), 64'(exp_ine));
    endtask

    initial begin
        // Reset state before any clock edge
        #2;
        chk("rst_out", 64'(output_o), 64'h0);
        chk("rst_ine", 64'(ine_o), 64'h0);
        chk("rst_mul", 64'(mul_fract_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Adder (combinational)
        add_i = 1'b1; add_opa_i = 28'h4000000; add_opb_i = 28'h4000000; #1;
        chk("add_co", 64'(add_co_o), 64'h1);
        chk("add_sum", 64'(add_sum_o), 64'h0);
        add_i = 1'b0; add_opb_i = 28'h2000000; #1;
        chk("sub_co", 64'(add_co_o), 64'h0);
        chk("sub_sum", 64'(add_sum_o), 64'h2000000);
        add_opa_i = 28'h0; add_opb_i = 28'h1; #1;
        chk("wrap_co", 64'(add_co_o), 64'h1);
        chk("wrap_sum", 64'(add_sum_o), 64'h7FFFFFF);

        // Multiplier, one cycle latency
        @(negedge clk_i);
        mul_fracta_i = 24'h800000; mul_fractb_i = 24'h800000;
        #1;
        chk("mul_lat", 64'(mul_fract_o), 64'h0);
        @(posedge clk_i); #1;
        chk("mul_half", 64'(mul_fract_o), 64'h400000000000);
        @(negedge clk_i);
        mul_fracta_i = 24'hFFFFFF; mul_fractb_i = 24'hFFFFFF;
        @(posedge clk_i); #1;
        chk("mul_max", 64'(mul_fract_o), 64'hFFFFFE000001);

        // Post-normalisation
        pn("one_plus_one", 32'h3F800000, 32'h3F800000, 28'h8000000, 8'h7F, 1'b0, 1'b0, 2'b00, 32'h40000000, 1'b0);
        pn("tie_even",     32'h3F800000, 32'h3F800000, 28'h4000004, 8'h7F, 1'b0, 1'b0, 2'b00, 32'h3F800000, 1'b1);
        pn("tie_pinf",     32'h3F800000, 32'h3F800000, 28'h4000004, 8'h7F, 1'b0, 1'b0, 2'b10, 32'h3F800001, 1'b1);
        pn("tie_odd",      32'h3F800000, 32'h3F800000, 28'h400000C, 8'h7F, 1'b0, 1'b0, 2'b00, 32'h3F800002, 1'b1);
        pn("rtz",          32'h3F800000, 32'h3F800000, 28'h4000004, 8'h7F, 1'b0, 1'b0, 2'b01, 32'h3F800000, 1'b1);
        pn("ninf_neg",     32'hBF800000, 32'h3F800000, 28'h4000004, 8'h7F, 1'b1, 1'b0, 2'b11, 32'hBF800001, 1'b1);
        pn("round_carry",  32'h3F800000, 32'h3F800000, 28'h7FFFFFC, 8'h7F, 1'b0, 1'b0, 2'b00, 32'h40000000, 1'b1);
        pn("lz_shift",     32'h3F800000, 32'h3E000000, 28'h0800000, 8'h7F, 1'b0, 1'b1, 2'b00, 32'h3E000000, 1'b0);
        pn("denormal",     32'h00100000, 32'h00000000, 28'h0800000, 8'h01, 1'b0, 1'b0, 2'b00, 32'h00100000, 1'b0);
        pn("denorm_norm",  32'h00400000, 32'h00400000, 28'h3FFFFFC, 8'h01, 1'b0, 1'b0, 2'b00, 32'h00800000, 1'b1);
        pn("overflow",     32'h7F000000, 32'h7F000000, 28'h8000000, 8'hFE, 1'b0, 1'b0, 2'b00, 32'h7F800000, 1'b1);
        pn("nan",          32'h7F800001, 32'h3F800000, 28'h4000000, 8'h7F, 1'b0, 1'b0, 2'b00, 32'h7FC00000, 1'b0);
        pn("inf_m_inf",    32'h7F800000, 32'h7F800000, 28'h4000000, 8'hFF, 1'b0, 1'b1, 2'b00, 32'h7FC00000, 1'b0);
        pn("minus_ninf",   32'h3F800000, 32'hFF800000, 28'h4000000, 8'hFF, 1'b0, 1'b1, 2'b00, 32'h7F800000, 1'b0);
        pn("cancel_rm11",  32'h3F800000, 32'h3F800000, 28'h0000000, 8'h7F, 1'b0, 1'b1, 2'b11, 32'h80000000, 1'b0);
        pn("cancel_rm00",  32'h3F800000, 32'h3F800000, 28'h0000000, 8'h7F, 1'b0, 1'b1, 2'b00, 32'h00000000, 1'b0);
        pn("neg_zeros",    32'h80000000, 32'h00000000, 28'h0000000, 8'h01, 1'b1, 1'b1, 2'b00, 32'h80000000, 1'b0);

        // Asynchronous reset mid-operation: all registers non-zero here
        pn("pre_rst",      32'h3F800000, 32'h3F800000, 28'h4000004, 8'h7F, 1'b0, 1'b0, 2'b10, 32'h3F800001, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_out", 64'(output_o), 64'h0);
        chk("arst_ine", 64'(ine_o), 64'h0);
        chk("arst_mul", 64'(mul_fract_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("reload_out", 64'(output_o), 64'h3F800001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
